// File: rtl/router_pkt_reg_pkg.sv
// ============================================================================
// Module      : router_pkt_reg_pkg
// Description : Shared router constants: header field layout, reserved address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkt_reg_pkg;

    localparam int          DEFAULT_WIDTH = 8;
    localparam int          ADDR_LSB      = 0;
    localparam int          ADDR_MSB      = 1;
    localparam logic [1:0]  INVALID_ADDR  = 2'b11;

    function automatic logic addr_is_valid(input logic [1:0] addr);
        return (addr != INVALID_ADDR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/router_parity_acc.sv
// ============================================================================
// Module      : router_parity_acc
// Description : Running XOR accumulator with synchronous clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_parity_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_parity
);

    logic [WIDTH-1:0] r_parity;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_parity <= '0;
        end else if (i_clr) begin
            r_parity <= '0;
        end else if (i_en) begin
            r_parity <= r_parity ^ i_data;
        end
    end

    assign o_parity = r_parity;

endmodule

`default_nettype wire

// File: rtl/router_pkt_reg.sv
// ============================================================================
// Module      : router_pkt_reg
// Description : Router datapath register: header/payload/parity capture,
//               full-FIFO hold-back, running parity and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_pkt_reg
    import router_pkt_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pkt_valid,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_header_byte;
    logic [WIDTH-1:0] r_hold_byte;
    logic [WIDTH-1:0] r_pkt_parity;
    logic [WIDTH-1:0] r_dout;
    logic             r_parity_done;
    logic             r_low_pkt_valid;
    logic             r_err;

    logic             w_par_en;
    logic [WIDTH-1:0] w_par_data;
    logic [WIDTH-1:0] w_int_parity;

    // Header folds in at lfd; payload bytes (including held ones) at ld.
    assign w_par_en   = lfd_state || (ld_state && pkt_valid && !full_state);
    assign w_par_data = lfd_state ? r_header_byte : data_in;

    router_parity_acc #(
        .WIDTH (WIDTH)
    ) u_parity_acc (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (detect_add),
        .i_en     (w_par_en),
        .i_data   (w_par_data),
        .o_parity (w_int_parity)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_header_byte <= '0;
        end else if (detect_add && pkt_valid &&
                     addr_is_valid(data_in[ADDR_MSB:ADDR_LSB])) begin
            r_header_byte <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dout      <= '0;
            r_hold_byte <= '0;
        end else if (lfd_state) begin
            r_dout <= r_header_byte;
        end else if (ld_state && !fifo_full) begin
            r_dout <= data_in;
        end else if (ld_state && fifo_full) begin
            r_hold_byte <= data_in;
        end else if (laf_state) begin
            r_dout <= r_hold_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pkt_parity    <= '0;
            r_low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            r_pkt_parity    <= data_in;
            r_low_pkt_valid <= 1'b1;
        end else if (rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end
    end

    // A parity byte that arrived while full completes on the laf cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_parity_done <= 1'b0;
        end else if (detect_add) begin
            r_parity_done <= 1'b0;
        end else if (ld_state && !fifo_full && !pkt_valid) begin
            r_parity_done <= 1'b1;
        end else if (laf_state && r_low_pkt_valid && !r_parity_done) begin
            r_parity_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (detect_add) begin
            r_err <= 1'b0;
        end else if (rst_int_reg && r_parity_done) begin
            r_err <= (w_int_parity != r_pkt_parity);
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_router_pkt_reg.sv
// ============================================================================
// Module      : tb_router_pkt_reg
// Description : Self-checking bench: directed vector table, hand sequence and
//               randomized strobes against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_pkt_reg;

    localparam logic [2:0] ST_NONE = 3'd0;
    localparam logic [2:0] ST_DA   = 3'd1;
    localparam logic [2:0] ST_LFD  = 3'd2;
    localparam logic [2:0] ST_LD   = 3'd3;
    localparam logic [2:0] ST_LAF  = 3'd4;
    localparam logic [2:0] ST_FULL = 3'd5;
    localparam logic [2:0] ST_RIR  = 3'd6;

    typedef struct packed {
        logic       rn;
        logic [2:0] st;
        logic [7:0] d;
        logic       pv;
        logic       ff;
        logic [7:0] e_dout;
        logic       e_pd;
        logic       e_lpv;
        logic       e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] data_in = '0;
    logic       pkt_valid = 1'b0;
    logic       fifo_full = 1'b0;
    logic       detect_add = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl[$];

    // Reference model state
    logic [7:0] m_hdr, m_hold, m_pkt_par, m_dout;
    logic       m_pd, m_lpv, m_err;
    logic [7:0] m_counted[$];

    always #5 clk = ~clk;

    router_pkt_reg #(.WIDTH(8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .data_in       (data_in),
        .pkt_valid     (pkt_valid),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
        .dout          (dout)
    );

    always @(posedge clk)
        assert ($onehot0({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}))
            else $error("strobes not one-hot");

    function automatic vec_t mk(input logic rn, input logic [2:0] st, input logic [7:0] d,
                                input logic pv, input logic ff, input logic [7:0] e_dout,
                                input logic e_pd, input logic e_lpv, input logic e_err);
        vec_t v;
        v.rn = rn; v.st = st; v.d = d; v.pv = pv; v.ff = ff;
        v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
        return v;
    endfunction

    task automatic apply(input logic rn, input logic [2:0] st, input logic [7:0] d,
                         input logic pv, input logic ff);
        @(negedge clk);
        resetn      = rn;
        data_in     = d;
        pkt_valid   = pv;
        fifo_full   = ff;
        detect_add  = (st == ST_DA);
        lfd_state   = (st == ST_LFD);
        ld_state    = (st == ST_LD);
        laf_state   = (st == ST_LAF);
        full_state  = (st == ST_FULL);
        rst_int_reg = (st == ST_RIR);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %02h expected %02h", name, step, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int step, input logic [7:0] e_dout,
                           input logic e_pd, input logic e_lpv, input logic e_err);
        chk({tag, ".dout"}, step, dout, e_dout);
        chk({tag, ".parity_done"}, step, {7'd0, parity_done}, {7'd0, e_pd});
        chk({tag, ".low_pkt_valid"}, step, {7'd0, low_pkt_valid}, {7'd0, e_lpv});
        chk({tag, ".err"}, step, {7'd0, err}, {7'd0, e_err});
    endtask

    function automatic logic [7:0] counted_xor();
        logic [7:0] x = '0;
        foreach (m_counted[i]) x ^= m_counted[i];
        return x;
    endfunction

    // Reference model: parity is the XOR of the bytes the packet rules count.
    task automatic model_step(input logic rn, input logic [2:0] st, input logic [7:0] d,
                              input logic pv, input logic ff);
        logic old_pd, old_lpv;
        old_pd  = m_pd;
        old_lpv = m_lpv;
        if (!rn) begin
            m_hdr = '0; m_hold = '0; m_pkt_par = '0; m_dout = '0;
            m_pd = 0; m_lpv = 0; m_err = 0;
            m_counted.delete();
        end else begin
            case (st)
                ST_DA: begin
                    if (pv && d[1:0] != 2'b11) m_hdr = d;
                    m_counted.delete();
                    m_pd = 0;
                    m_err = 0;
                end
                ST_LFD: begin
                    m_dout = m_hdr;
                    m_counted.push_back(m_hdr);
                end
                ST_LD: begin
                    if (ff) m_hold = d;
                    else    m_dout = d;
                    if (pv) m_counted.push_back(d);
                    else begin
                        m_pkt_par = d;
                        m_lpv = 1;
                        if (!ff) m_pd = 1;
                    end
                end
                ST_LAF: begin
                    m_dout = m_hold;
                    if (old_lpv && !old_pd) m_pd = 1;
                end
                ST_RIR: begin
                    if (old_pd) m_err = (counted_xor() != m_pkt_par);
                    m_lpv = 0;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        // --- directed table ---
        tbl.push_back(mk(0, ST_NONE, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        // good packet, no full
        tbl.push_back(mk(1, ST_DA,   8'h06, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, ST_LFD,  8'hFF, 1, 0, 8'h06, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'hA5, 1, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'hA3, 0, 0, 8'hA3, 1, 1, 0));
        tbl.push_back(mk(1, ST_RIR,  8'h00, 0, 0, 8'hA3, 1, 0, 0));
        // bad parity
        tbl.push_back(mk(1, ST_DA,   8'h06, 1, 0, 8'hA3, 0, 0, 0));
        tbl.push_back(mk(1, ST_LFD,  8'h00, 1, 0, 8'h06, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'hA5, 1, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'h00, 0, 0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, ST_RIR,  8'h00, 0, 0, 8'h00, 1, 0, 1));
        // invalid address: header stays 0x06, err/parity_done clear
        tbl.push_back(mk(1, ST_DA,   8'h07, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, ST_LFD,  8'h00, 1, 0, 8'h06, 0, 0, 0));
        // full mid-payload
        tbl.push_back(mk(1, ST_DA,   8'h0D, 1, 0, 8'h06, 0, 0, 0));
        tbl.push_back(mk(1, ST_LFD,  8'h00, 1, 0, 8'h0D, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'h11, 1, 0, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'h22, 1, 1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, ST_FULL, 8'h99, 1, 1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, ST_LAF,  8'h99, 1, 0, 8'h22, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'h33, 1, 0, 8'h33, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'h0D, 0, 0, 8'h0D, 1, 1, 0));
        tbl.push_back(mk(1, ST_RIR,  8'h00, 0, 0, 8'h0D, 1, 0, 0));
        // parity byte while full
        tbl.push_back(mk(1, ST_DA,   8'h06, 1, 0, 8'h0D, 0, 0, 0));
        tbl.push_back(mk(1, ST_LFD,  8'h00, 1, 0, 8'h06, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'hA5, 1, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'hA3, 0, 1, 8'hA5, 0, 1, 0));
        tbl.push_back(mk(1, ST_FULL, 8'h00, 0, 1, 8'hA5, 0, 1, 0));
        tbl.push_back(mk(1, ST_LAF,  8'h00, 0, 0, 8'hA3, 1, 1, 0));
        tbl.push_back(mk(1, ST_RIR,  8'h00, 0, 0, 8'hA3, 1, 0, 0));
        // reset mid-packet, then a clean good packet
        tbl.push_back(mk(1, ST_DA,   8'h06, 1, 0, 8'hA3, 0, 0, 0));
        tbl.push_back(mk(1, ST_LFD,  8'h00, 1, 0, 8'h06, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'hA5, 1, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, ST_LD,   8'h5A, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, ST_DA,   8'h06, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, ST_LFD,  8'h00, 1, 0, 8'h06, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'hA5, 1, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(1, ST_LD,   8'hA3, 0, 0, 8'hA3, 1, 1, 0));
        tbl.push_back(mk(1, ST_RIR,  8'h00, 0, 0, 8'hA3, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rn, tbl[i].st, tbl[i].d, tbl[i].pv, tbl[i].ff);
            chk_all("tbl", i, tbl[i].e_dout, tbl[i].e_pd, tbl[i].e_lpv, tbl[i].e_err);
        end

        // --- hand sequence: bad parity via the full path, err holds until detect_add ---
        apply(1, ST_DA,   8'h06, 1, 0); chk_all("seq", 0, 8'hA3, 0, 0, 0);
        apply(1, ST_LFD,  8'h00, 1, 0); chk_all("seq", 1, 8'h06, 0, 0, 0);
        apply(1, ST_LD,   8'hA5, 1, 0); chk_all("seq", 2, 8'hA5, 0, 0, 0);
        apply(1, ST_LD,   8'h5A, 0, 1); chk_all("seq", 3, 8'hA5, 0, 1, 0);
        apply(1, ST_LAF,  8'h00, 0, 0); chk_all("seq", 4, 8'h5A, 1, 1, 0);
        apply(1, ST_RIR,  8'h00, 0, 0); chk_all("seq", 5, 8'h5A, 1, 0, 1);
        apply(1, ST_NONE, 8'h00, 0, 0); chk_all("seq", 6, 8'h5A, 1, 0, 1);
        apply(1, ST_DA,   8'h03, 1, 0); chk_all("seq", 7, 8'h5A, 0, 0, 0);

        // --- randomized strobes against the reference model ---
        apply(0, ST_NONE, 8'h00, 0, 0);
        model_step(0, ST_NONE, 8'h00, 0, 0);
        chk_all("rnd_rst", 0, m_dout, m_pd, m_lpv, m_err);
        for (int i = 0; i < 3000; i++) begin
            logic       rn, pv, ff;
            logic [2:0] st;
            logic [7:0] d;
            rn = ($urandom_range(0, 49) != 0);
            st = 3'($urandom_range(0, 6));
            d  = 8'($urandom);
            pv = ($urandom_range(0, 3) != 0);
            ff = ($urandom_range(0, 2) == 0);
            apply(rn, st, d, pv, ff);
            model_step(rn, st, d, pv, ff);
            chk_all("rnd", i, m_dout, m_pd, m_lpv, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
